// File: rtl/tdm_slot_sequencer.sv
// rtl/tdm_slot_sequencer.sv - serialises 4-slot frames onto a 1-to-4 demux with optional inter-frame gap
module tdm_slot_sequencer #(
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic [3:0] en_mask,
  output logic       i,
  output logic [1:0] s,
  output logic       slot_valid,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t     state, state_nx;
  logic [3:0] gcnt, gcnt_nx;
  logic [3:0] data, data_nx;
  logic [3:0] mask, mask_nx;
  logic [1:0] s_nx;
  logic       accept;
  logic       sv_nx, i_nx, fd_nx, cnt_inc;

  // Ready depends on registered state only, so there is no path from din_valid.
  always_comb begin
    din_ready = 1'b0;
    case (state)
      ST_IDLE: din_ready = 1'b1;
      ST_SEND: din_ready = (s == 2'd3) && (GAP == 0);
      ST_GAP:  din_ready = (gcnt == GAP_LAST);
      default: din_ready = 1'b0;
    endcase
  end

  assign accept = din_valid & din_ready;

  always_comb begin
    state_nx = state;
    s_nx     = 2'd0;
    gcnt_nx  = gcnt;
    data_nx  = data;
    mask_nx  = mask;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_SEND;
          data_nx  = din;
          mask_nx  = en_mask;
        end
      end
      ST_SEND: begin
        if (s != 2'd3) begin
          s_nx = s + 2'd1;
        end else if (accept) begin
          data_nx = din;
          mask_nx = en_mask;
        end else if (GAP == 0) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_GAP;
          gcnt_nx  = 4'd0;
        end
      end
      ST_GAP: begin
        if (din_ready) begin
          if (accept) begin
            state_nx = ST_SEND;
            data_nx  = din;
            mask_nx  = en_mask;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          gcnt_nx = gcnt + 4'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Slot outputs are precomputed from next state so they leave the flops aligned with s.
  always_comb begin
    sv_nx   = (state_nx == ST_SEND) && mask_nx[s_nx];
    i_nx    = sv_nx && data_nx[s_nx];
    fd_nx   = (state_nx == ST_SEND) && (s_nx == 2'd3);
    cnt_inc = (state == ST_SEND) && (s == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      s          <= 2'd0;
      gcnt       <= 4'd0;
      data       <= 4'd0;
      mask       <= 4'd0;
      i          <= 1'b0;
      slot_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      state      <= state_nx;
      s          <= s_nx;
      gcnt       <= gcnt_nx;
      data       <= data_nx;
      mask       <= mask_nx;
      i          <= i_nx;
      slot_valid <= sv_nx;
      frame_done <= fd_nx;
      if (cnt_inc) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_tdm_slot_sequencer.sv
// tb/tb_tdm_slot_sequencer.sv - scoreboard bench for tdm_slot_sequencer (GAP=0 and GAP=2 instances)
module tb_tdm_slot_sequencer;

  typedef struct {
    logic [3:0] i;
    logic [3:0] sv;
    logic [7:0] cnt;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din0 = 4'd0, en0 = 4'd0, din1 = 4'd0, en1 = 4'd0;
  logic       dv0 = 1'b0, dv1 = 1'b0;
  logic       rdy0, rdy1, i0, i1, sv0, sv1, fd0, fd1;
  logic [1:0] s0, s1;
  logic [7:0] cnt0, cnt1;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] mc[2];
  logic [7:0] hs[2];
  logic [3:0] hi[2];
  logic [3:0] hv[2];
  int         last[2];

  always #5 clk = ~clk;

  tdm_slot_sequencer #(.GAP(0)) u0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(dv0), .din_ready(rdy0), .en_mask(en0),
    .i(i0), .s(s0), .slot_valid(sv0), .frame_done(fd0), .frame_cnt(cnt0)
  );

  tdm_slot_sequencer #(.GAP(2)) u1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .din_ready(rdy1), .en_mask(en1),
    .i(i1), .s(s1), .slot_valid(sv1), .frame_done(fd1), .frame_cnt(cnt1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic rdy(input int k);
    return (k == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic svk(input int k);
    return (k == 0) ? sv0 : sv1;
  endfunction

  // Caller sits at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic offer(input int k, input logic [3:0] d, input logic [3:0] m, input int waits, input int gap);
    exp_t e;
    if (k == 0) begin din0 = d; en0 = m; dv0 = 1'b1; end
    else        begin din1 = d; en1 = m; dv1 = 1'b1; end
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      chk("ready_low", rdy(k), 1'b0);
      if (k == 1 && w >= 4) chk("gap_slot_valid", svk(k), 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("ready_high", rdy(k), 1'b1);
    if (k == 1) chk("gap_slot_valid", svk(k), 1'b0);
    @(posedge clk);
    e.i = d & m; e.sv = m; e.cnt = mc[k]; e.gap = gap;
    mc[k] = mc[k] + 8'd1;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    #1;
  endtask

  task automatic mon(input int k, input logic [1:0] s, input logic i, input logic sv,
                     input logic fd, input logic [7:0] cnt);
    exp_t e;
    int   n;
    hs[k] = {s, hs[k][7:2]};
    hi[k] = {i, hi[k][3:1]};
    hv[k] = {sv, hv[k][3:1]};
    if (fd || s == 2'd3) chk("done_only_at_s3", fd, (s == 2'd3));
    if (fd) begin
      n = (k == 0) ? q0.size() : q1.size();
      if (n == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: inst %0d got frame_done expected none (t=%0t)", k, $time);
      end else begin
        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk("slot_order", hs[k], 8'he4);
        chk("frame_i", hi[k], e.i);
        chk("frame_slot_valid", hv[k], e.sv);
        chk("frame_cnt_at_done", cnt, e.cnt);
        if (e.gap != 0) chk("frame_spacing", cyc - last[k], e.gap);
      end
      last[k] = cyc;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      mon(0, s0, i0, sv0, fd0, cnt0);
      mon(1, s1, i1, sv1, fd1, cnt1);
    end
  end

  initial begin
    mc[0] = 8'd0; mc[1] = 8'd0;
    hs[0] = 8'd0; hs[1] = 8'd0; hi[0] = 4'd0; hi[1] = 4'd0; hv[0] = 4'd0; hv[1] = 4'd0;
    last[0] = 0; last[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_s", s0, 2'd0);
    chk("rst_i", i0, 1'b0);
    chk("rst_slot_valid", sv0, 1'b0);
    chk("rst_frame_done", fd0, 1'b0);
    chk("rst_frame_cnt", cnt0, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", rdy0, 1'b1);
    @(posedge clk); #1;

    // Single frame, then back to idle
    offer(0, 4'b1011, 4'b1111, 0, 0);
    dv0 = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("idle_s", s0, 2'd0);
    chk("idle_slot_valid", sv0, 1'b0);
    chk("idle_ready", rdy0, 1'b1);
    chk("cnt_after_one", cnt0, 8'd1);
    @(posedge clk); #1;

    // Back-to-back; second din presented during s<3 must not be latched early
    offer(0, 4'b1010, 4'b1111, 0, 0);
    offer(0, 4'b0101, 4'b1111, 3, 4);
    dv0 = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("cnt_after_b2b", cnt0, 8'd3);
    @(posedge clk); #1;

    // Partial and empty masks
    offer(0, 4'b1111, 4'b0101, 0, 0);
    dv0 = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    offer(0, 4'b1111, 4'b0000, 0, 0);
    dv0 = 1'b0;
    repeat (5) begin @(posedge clk); #1; end

    // Abort mid-frame at s=2
    offer(0, 4'b1111, 4'b1111, 0, 0);
    dv0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_at_s2", s0, 2'd2);
    rst = 1'b1;
    @(posedge clk);
    void'(q0.pop_back());
    mc[0] = 8'd0; mc[1] = 8'd0;
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_s", s0, 2'd0);
    chk("abort_slot_valid", sv0, 1'b0);
    chk("abort_frame_done", fd0, 1'b0);
    chk("abort_cnt", cnt0, 8'd0);
    chk("abort_ready", rdy0, 1'b1);
    @(posedge clk); #1;

    // Reset wins over a simultaneous acceptance
    din0 = 4'b1111; en0 = 4'b1111; dv0 = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; dv0 = 1'b0;
    @(negedge clk);
    chk("prio_s", s0, 2'd0);
    chk("prio_slot_valid", sv0, 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("prio_cnt", cnt0, 8'd0);
    @(posedge clk); #1;

    // GAP=2 instance, valid held high across the gap
    offer(1, 4'b1100, 4'b1111, 0, 0);
    offer(1, 4'b0011, 4'b1111, 5, 6);
    dv1 = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("gap_cnt", cnt1, 8'd2);
    chk("gap_idle_ready", rdy1, 1'b1);
    @(posedge clk); #1;

    // 256 back-to-back frames wrap the counter
    for (int k = 0; k < 256; k++) begin
      logic [7:0] kk;
      kk = 8'(k);
      offer(0, kk[7:4] ^ kk[3:0], kk[3:0] ^ 4'ha, (k == 0) ? 0 : 3, (k == 0) ? 0 : 4);
    end
    dv0 = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("cnt_wrap", cnt0, 8'd0);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
